// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the UART transmit arbiter, its requesters and
// the shared UART_tx.
//   req/req_data/ack : requester side (one byte per request, ack on completion)
//   trmt/tx_data     : launch strobe and byte to UART_tx
//   tx_done          : UART_tx completion level
//   err/busy/gnt_id  : abort pulse, activity flag, current/last grant index
// slave  = arbiter view, master = requester/transmitter (environment) view.
interface uart_tx_arb_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              trmt;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              busy;
    logic [2:0]        gnt_id;

    modport slave (
        input  req, req_data, tx_done,
        output ack, err, trmt, tx_data, busy, gnt_id
    );

    modport master (
        output req, req_data, tx_done,
        input  ack, err, trmt, tx_data, busy, gnt_id
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART_tx among NREQ requesters.
// Grants one byte at a time, strobes trmt, waits for tx_done, then acks the
// winner and re-arbitrates. A watchdog aborts a frame that never completes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uart_tx_arb_if.slave (req, req_data, ack, err, trmt, tx_data,
//           tx_done, busy, gnt_id)
module uart_tx_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      last;
    logic [2:0]      gnt_id;
    logic [7:0]      tx_data;
    logic [NREQ-1:0] ack_r;
    logic            err_r;
    logic [TO_W-1:0] wdog;

    logic [7:0]      req_ext;
    logic [3:0]      idx;
    logic            found;
    logic [2:0]      win;
    logic [7:0]      sel_data;
    logic            to_hit;

    assign to_hit = (wdog == TO_W'(TIMEOUT));

    // Search starts one past the last served requester so it ends up with
    // the lowest priority; idx stays below 2*NREQ, so one subtraction wraps.
    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = bus.req;
        found              = 1'b0;
        win                = '0;
        idx                = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, last} + 4'(k);
            if (idx >= 4'(NREQ))
                idx = idx - 4'(NREQ);
            if (!found && req_ext[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (win == 3'(i))
                sel_data = bus.req_data[8*i +: 8];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (found) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_GUARD;
            // tx_done may still be high from the previous frame here.
            S_GUARD:  state_nxt = S_WAIT;
            S_WAIT:   if (bus.tx_done || to_hit) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last    <= 3'(NREQ - 1);
            gnt_id  <= '0;
            tx_data <= '0;
            ack_r   <= '0;
            err_r   <= 1'b0;
            wdog    <= '0;
        end else begin
            state <= state_nxt;
            ack_r <= '0;
            err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt_id  <= win;
                        tx_data <= sel_data;
                    end
                end
                S_LAUNCH: wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // Completion beats a simultaneous timeout.
                    if (bus.tx_done) begin
                        for (int i = 0; i < NREQ; i++)
                            if (gnt_id == 3'(i))
                                ack_r[i] <= 1'b1;
                        last <= gnt_id;
                    end else if (to_hit) begin
                        err_r <= 1'b1;
                        last  <= gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.trmt    = (state == S_LAUNCH);
    assign bus.busy    = (state != S_IDLE);
    assign bus.tx_data = tx_data;
    assign bus.gnt_id  = gnt_id;
    assign bus.ack     = ack_r;
    assign bus.err     = err_r;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one UART_tx transmitter among NREQ byte-producing requesters (telemetry, command echo, debug).
- Accepts a byte per request, drives trmt/tx_data into UART_tx and waits for tx_done.
- Acknowledges the winning requester, then re-arbitrates.
- A watchdog recovers from a transmitter that never completes.

Parameters:
NREQ, 3, number of requesters (2..8)
TIMEOUT, 65535, max clk cycles in WAIT before abort (one frame at 19200 baud / 50 MHz is about 26042 cycles)
TO_W, 16, width of watchdog counter; must hold TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req  input  NREQ  per-requester byte request; held high until matching ack
req_data  input  8*NREQ  byte for requester i at [8*i+7:8*i]; stable while req[i] high
ack  output  NREQ  one-cycle pulse: requester's byte fully transmitted
err  output  1  one-cycle pulse: watchdog abort of current byte
trmt  output  1  one-cycle transmit strobe to UART_tx
tx_data  output  8  byte to UART_tx; registered, stable from trmt until next grant
tx_done  input  1  UART_tx completion flag: level, set at end of frame, cleared by trmt
busy  output  1  high in every state except IDLE
gnt_id  output  3  index of current/last granted requester

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; ack=0, err=0, trmt=0, tx_data=8'h00, busy=0, gnt_id=0; last pointer=NREQ-1 so requester 0 has first priority; watchdog=0.
- Reset mid-transfer behaves the same; no ack or err is issued for the aborted byte.
- IDLE:
  - If req != 0, pick the first set bit searching from (last+1) mod NREQ, wrapping.
  - Latch gnt_id, tx_data = that requester's req_data slice; go LAUNCH.
  - If req == 0, stay.
- LAUNCH: trmt=1 for exactly this cycle; clear watchdog; go GUARD.
- GUARD: one cycle, trmt=0. tx_done is ignored here because it may still be high from the previous frame. Go WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If tx_done=1: pulse ack[gnt_id] next cycle, last=gnt_id, go IDLE.
  - Else if watchdog==TIMEOUT: pulse err, last=gnt_id, go IDLE; no ack is issued.
  - tx_done and timeout in the same cycle: tx_done wins.
- Latency and throughput:
  - req high in IDLE at edge N gives trmt=1 during cycle N+1.
  - ack pulses the cycle after tx_done is sampled high.
  - At least 1 IDLE cycle between bytes.
- ack/err are registered outputs asserted in the IDLE cycle following WAIT.
- A requester seeing its ack must drop req that cycle or re-present new data. Still-high req is treated as a new byte and arbitrated normally.
- req[i] dropping after grant does not abort the byte; the ack is still issued.
- New or changed req/req_data during LAUNCH/GUARD/WAIT is not sampled.
- Fairness: after requester k is served, k has lowest priority. With all requesters continuously requesting, grants rotate 0,1,2,0,...
- Bits of req above NREQ-1 do not exist; gnt_id is zero-extended to 3 bits.

Test Plan:
- Single: after reset, req=3'b001, req_data[7:0]=8'h75, loop TX into UART_rcv -> one trmt pulse one cycle after req, tx_data=8'h75; cmd=8'h75 with rdy=1; ack=3'b001 one cycle after tx_done; busy low afterward.
- Round-robin: req=3'b111 held with data 8'h42/8'hF0/8'hA5 -> grants 0,1,2,0 in order; receiver sees 42,F0,A5,42; exactly one trmt per byte.
- Priority rotation: serve requester 1, then req=3'b011 -> requester 0 is not granted before 1 only if last=1; grant goes to 0 (search from 2 wraps to 0).
- Stale tx_done: back-to-back bytes with tx_done still high at LAUNCH -> GUARD cycle prevents a premature ack; ack only after the second frame completes.
- Watchdog: TIMEOUT=100, tie tx_done=0 -> err pulses once after 100 WAIT cycles, no ack, state returns to IDLE, next requester granted.
- Reset mid-WAIT: assert rst_n=0 for one clk during a frame -> trmt, ack, err, busy, tx_data=0 next cycle; requester 0 has priority on restart.
